// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and branch-flush control.
// Optional IDEX_PERF_CNT_EN adds stall/flush cycle counters (stall_cnt, flush_cnt).
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWrite_D,
  input  logic            MemWrite_D,
  input  logic            ResultSrc_D,
  input  logic            ALUSrc_D,
  input  logic            Branch_D,
  input  logic [2:0]      ALUControl_D,
  input  logic [XLEN-1:0] RD1_D,
  input  logic [XLEN-1:0] RD2_D,
  input  logic [XLEN-1:0] PC_D,
  input  logic [XLEN-1:0] PCPlus4_D,
  input  logic [XLEN-1:0] ImmExt_D,
  input  logic [RA_W-1:0] Rs1_D,
  input  logic [RA_W-1:0] Rs2_D,
  input  logic [RA_W-1:0] Rd_D,
  input  logic            PCSrc_E,
  output logic            RegWrite_E,
  output logic            MemWrite_E,
  output logic            ResultSrc_E,
  output logic            ALUSrc_E,
  output logic            Branch_E,
  output logic [2:0]      ALUControl_E,
  output logic [XLEN-1:0] RD1_E,
  output logic [XLEN-1:0] RD2_E,
  output logic [XLEN-1:0] PC_E,
  output logic [XLEN-1:0] PCPlus4_E,
  output logic [XLEN-1:0] ImmExt_E,
  output logic [RA_W-1:0] Rs1_E,
  output logic [RA_W-1:0] Rs2_E,
  output logic [RA_W-1:0] Rd_E,
  output logic            Valid_E,
  output logic            Stall_F,
  output logic            Stall_D,
  output logic            Flush_D
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  logic lduse;
  logic bubble;

  // Rs2 is compared for every instruction; spurious I-type stalls are harmless.
  assign lduse = Valid_E & ResultSrc_E & RegWrite_E & (Rd_E != '0) &
                 ((Rd_E == Rs1_D) | (Rd_E == Rs2_D));

  assign Stall_F = lduse & ~PCSrc_E;
  assign Stall_D = lduse & ~PCSrc_E;
  assign Flush_D = PCSrc_E;
  assign bubble  = PCSrc_E | lduse;

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      RegWrite_E   <= 1'b0;
      MemWrite_E   <= 1'b0;
      ResultSrc_E  <= 1'b0;
      ALUSrc_E     <= 1'b0;
      Branch_E     <= 1'b0;
      ALUControl_E <= 3'b000;
      RD1_E        <= '0;
      RD2_E        <= '0;
      PC_E         <= '0;
      PCPlus4_E    <= '0;
      ImmExt_E     <= '0;
      Rs1_E        <= '0;
      Rs2_E        <= '0;
      Rd_E         <= '0;
      Valid_E      <= 1'b0;
    end else begin
      RegWrite_E   <= RegWrite_D;
      MemWrite_E   <= MemWrite_D;
      ResultSrc_E  <= ResultSrc_D;
      ALUSrc_E     <= ALUSrc_D;
      Branch_E     <= Branch_D;
      ALUControl_E <= ALUControl_D;
      RD1_E        <= RD1_D;
      RD2_E        <= RD2_D;
      PC_E         <= PC_D;
      PCPlus4_E    <= PCPlus4_D;
      ImmExt_E     <= ImmExt_D;
      Rs1_E        <= Rs1_D;
      Rs2_E        <= Rs2_D;
      Rd_E         <= Rd_D;
      Valid_E      <= 1'b1;
    end
  end

`ifdef IDEX_PERF_CNT_EN
  // Free-running counters; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + {31'd0, Stall_D};
      flush_cnt <= flush_cnt + {31'd0, Flush_D};
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; counter checks build only with IDEX_PERF_CNT_EN.
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam int RA_W = 5;

  logic clk = 1'b0;
  logic rst;
  logic RegWrite_D, MemWrite_D, ResultSrc_D, ALUSrc_D, Branch_D;
  logic [2:0] ALUControl_D;
  logic [XLEN-1:0] RD1_D, RD2_D, PC_D, PCPlus4_D, ImmExt_D;
  logic [RA_W-1:0] Rs1_D, Rs2_D, Rd_D;
  logic PCSrc_E;
  logic RegWrite_E, MemWrite_E, ResultSrc_E, ALUSrc_E, Branch_E;
  logic [2:0] ALUControl_E;
  logic [XLEN-1:0] RD1_E, RD2_E, PC_E, PCPlus4_E, ImmExt_E;
  logic [RA_W-1:0] Rs1_E, Rs2_E, Rd_E;
  logic Valid_E, Stall_F, Stall_D, Flush_D;
`ifdef IDEX_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk(clk), .rst(rst),
    .RegWrite_D(RegWrite_D), .MemWrite_D(MemWrite_D), .ResultSrc_D(ResultSrc_D),
    .ALUSrc_D(ALUSrc_D), .Branch_D(Branch_D), .ALUControl_D(ALUControl_D),
    .RD1_D(RD1_D), .RD2_D(RD2_D), .PC_D(PC_D), .PCPlus4_D(PCPlus4_D), .ImmExt_D(ImmExt_D),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_D(Rd_D), .PCSrc_E(PCSrc_E),
    .RegWrite_E(RegWrite_E), .MemWrite_E(MemWrite_E), .ResultSrc_E(ResultSrc_E),
    .ALUSrc_E(ALUSrc_E), .Branch_E(Branch_E), .ALUControl_E(ALUControl_E),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .PC_E(PC_E), .PCPlus4_E(PCPlus4_E), .ImmExt_E(ImmExt_E),
    .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E), .Valid_E(Valid_E),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Flush_D(Flush_D)
`ifdef IDEX_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one decoded instruction: controls, registers, and a PC-derived data set.
  task automatic drive(input logic rw, input logic mw, input logic rs, input logic as,
                       input logic br, input logic [2:0] alu,
                       input logic [RA_W-1:0] s1, input logic [RA_W-1:0] s2,
                       input logic [RA_W-1:0] d, input logic [31:0] v1,
                       input logic [31:0] v2, input logic [31:0] pc);
    RegWrite_D = rw; MemWrite_D = mw; ResultSrc_D = rs; ALUSrc_D = as; Branch_D = br;
    ALUControl_D = alu; Rs1_D = s1; Rs2_D = s2; Rd_D = d;
    RD1_D = v1; RD2_D = v2; PC_D = pc; PCPlus4_D = pc + 32'd4; ImmExt_D = 32'h10;
    #1;
  endtask

  task automatic drive_lw(input logic [RA_W-1:0] d);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 5'd2, 5'd0, d, 32'h40, 32'h0, 32'h200);
  endtask

  initial begin
    rst = 1'b1; PCSrc_E = 1'b0;
    drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
          $urandom, $urandom, $urandom);
    step();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'b111, 5'd5, 5'd6, 5'd7,
          $urandom, $urandom, $urandom);
    step();
    chk("rst_valid", Valid_E, 0);
    chk("rst_regwrite", RegWrite_E, 0);
    chk("rst_memwrite", MemWrite_E, 0);
    chk("rst_rd1", RD1_E, 0);
    chk("rst_rd", Rd_E, 0);
    chk("rst_alu", ALUControl_E, 0);
    chk("rst_stall_f", Stall_F, 0);
    chk("rst_flush", Flush_D, 0);

    // add x3,x1,x2
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h100);
    step();
    chk("add_valid", Valid_E, 1);
    chk("add_regwrite", RegWrite_E, 1);
    chk("add_rd", Rd_E, 3);
    chk("add_rd1", RD1_E, 5);
    chk("add_rd2", RD2_E, 7);
    chk("add_pc4", PCPlus4_E, 32'h104);
    chk("add_stall", Stall_D, 0);

    // lw x5 then add x6,x5,x1
    drive_lw(5'd5);
    step();
    chk("lw_resultsrc", ResultSrc_E, 1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd5, 5'd1, 5'd6, 32'd11, 32'd22, 32'h204);
    chk("lu_stall_f", Stall_F, 1);
    chk("lu_stall_d", Stall_D, 1);
    chk("lu_flush", Flush_D, 0);
    step();
    chk("lu_bubble_valid", Valid_E, 0);
    chk("lu_bubble_rw", RegWrite_E, 0);
    chk("lu_bubble_rd", Rd_E, 0);
    chk("lu_stall_released", Stall_D, 0);
    step();
    chk("lu_add_valid", Valid_E, 1);
    chk("lu_add_rd", Rd_E, 6);
    chk("lu_add_rd1", RD1_E, 11);

    // lw x0 followed by use of x0
    drive_lw(5'd0);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd4, 32'd1, 32'd2, 32'h208);
    chk("x0_stall", Stall_D, 0);
    // lw x5 followed by add x9,x7,x8
    drive_lw(5'd5);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 5'd7, 5'd8, 5'd9, 32'd3, 32'd4, 32'h20c);
    chk("nomatch_stall", Stall_D, 0);
    // Rs2 match (sw-like use of x5)
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 5'd7, 5'd5, 5'd0, 32'd3, 32'd4, 32'h20c);
    chk("rs2_stall", Stall_D, 1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 5'd7, 5'd8, 5'd9, 32'd3, 32'd4, 32'h20c);
    step();
    chk("nomatch_rd", Rd_E, 9);
    chk("nomatch_alu", ALUControl_E, 3'b010);

    // Taken branch: D holds a store/branch-like word that must be squashed.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 5'd1, 5'd2, 5'd0, 32'd8, 32'd9, 32'h300);
    PCSrc_E = 1'b1; #1;
    chk("br_flush", Flush_D, 1);
    chk("br_stall", Stall_D, 0);
    step();
    PCSrc_E = 1'b0; #1;
    chk("br_valid", Valid_E, 0);
    chk("br_memwrite", MemWrite_E, 0);
    chk("br_branch", Branch_E, 0);
    chk("br_flush_clear", Flush_D, 0);

    // Branch and load-use together: branch wins, no stall.
    drive_lw(5'd5);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd5, 5'd5, 5'd6, 32'd1, 32'd1, 32'h400);
    PCSrc_E = 1'b1; #1;
    chk("brlu_stall_f", Stall_F, 0);
    chk("brlu_flush", Flush_D, 1);
    step();
    PCSrc_E = 1'b0; #1;
    chk("brlu_valid", Valid_E, 0);

    // Reset during a stall.
    drive_lw(5'd5);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd5, 5'd1, 5'd6, 32'd1, 32'd1, 32'h500);
    chk("rststall_pre", Stall_D, 1);
    rst = 1'b1;
    step();
    rst = 1'b0; #1;
    chk("rststall_valid", Valid_E, 0);
    chk("rststall_stall", Stall_D, 0);
    step();
    chk("rststall_capture", Rd_E, 6);
    chk("rststall_cvalid", Valid_E, 1);

`ifdef IDEX_PERF_CNT_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_lw(5'd5);
      step();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd5, 5'd1, 5'd6, 32'd1, 32'd1, 32'h600);
      step();
      step();
    end
    for (int i = 0; i < 2; i++) begin
      PCSrc_E = 1'b1;
      step();
      PCSrc_E = 1'b0;
      step();
    end
    chk("cnt_stall", stall_cnt, 3);
    chk("cnt_flush", flush_cnt, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("cnt_stall_rst", stall_cnt, 0);
    chk("cnt_flush_rst", flush_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline boundary of the RV32I 5-stage core.
- Registers the main/ALU decoder control outputs and the decode-stage operands into execute.
- Contains load-use hazard detection: generates fetch/decode stall and inserts a bubble into EX.
- Converts a taken branch resolved in EX into decode flush plus EX bubble.

Parameters:
- XLEN, 32, datapath width (RD1, RD2, PC, PCPlus4, ImmExt).
- RA_W, 5, register-address width (Rs1, Rs2, Rd).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- RegWrite_D  input  1  decode control.
- MemWrite_D  input  1  decode control.
- ResultSrc_D  input  1  decode control; 1 = load result.
- ALUSrc_D  input  1  decode control.
- Branch_D  input  1  decode control.
- ALUControl_D  input  3  ALU operation from ALU decoder.
- RD1_D, RD2_D  input  XLEN  register-file read data.
- PC_D, PCPlus4_D, ImmExt_D  input  XLEN  decode-stage PC, PC+4, extended immediate.
- Rs1_D, Rs2_D, Rd_D  input  RA_W  decode-stage register addresses.
- PCSrc_E  input  1  taken branch resolved in EX this cycle.
- RegWrite_E, MemWrite_E, ResultSrc_E, ALUSrc_E, Branch_E  output  1  registered controls.
- ALUControl_E  output  3  registered ALU operation.
- RD1_E, RD2_E, PC_E, PCPlus4_E, ImmExt_E  output  XLEN  registered data.
- Rs1_E, Rs2_E, Rd_E  output  RA_W  registered addresses.
- Valid_E  output  1  EX holds a real instruction; 0 = bubble.
- Stall_F, Stall_D  output  1  hold PC and IF/ID register.
- Flush_D  output  1  clear IF/ID register.

Behaviour:
- Reset: synchronous; when rst=1 at a clock edge, every registered output goes to 0, including Valid_E.
- Reset outputs: Stall_F, Stall_D and Flush_D are combinational and are 0 while Valid_E=0 and PCSrc_E=0.
- Load-use detection, combinational: lduse = Valid_E & ResultSrc_E & RegWrite_E & (Rd_E != 0) & ((Rd_E == Rs1_D) | (Rd_E == Rs2_D)).
- Rs2 match is checked for every instruction type. Conservative extra stalls on I-type are accepted.
- Stall outputs: Stall_F = Stall_D = lduse & ~PCSrc_E.
- Flush output: Flush_D = PCSrc_E.
- Per-edge update priority, highest first:
  1. rst: all outputs cleared.
  2. PCSrc_E: bubble.
  3. lduse: bubble.
  4. Otherwise: capture all _D inputs, Valid_E <= 1.
- Bubble definition: all control outputs = 0, ALUControl_E = 0, Valid_E = 0, data and address outputs = 0.
- A bubble therefore can never write the register file or memory, and never re-triggers lduse or a branch.
- Latency: one cycle from D input to E output.
- Load-use stall length: exactly one cycle. After the bubble, Valid_E = 0, so lduse deasserts and the stalled instruction is captured on the next edge.
- PCSrc_E with lduse: PCSrc_E wins; stalls are suppressed.
  - This combination cannot occur with a legal decoder, since a branch has ResultSrc = 0. It is still defined.
- Reset asserted mid-stall: stall and bubble state is discarded; the next cycle starts with Valid_E = 0.
- No x-propagation: every output is driven on every path.

Optional Feature:
- Macro: IDEX_PERF_CNT_EN.
- When defined, adds two ports:
  - stall_cnt  output  32  counts cycles with Stall_D = 1.
  - flush_cnt  output  32  counts cycles with Flush_D = 1.
- Both counters clear on rst and wrap modulo 2^32 without saturating.
- When not defined, neither the ports nor the counters exist, and all other behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 2 cycles with random _D inputs → every _E output 0, Valid_E 0, Stall_F/Stall_D/Flush_D 0.
- Pass-through: drive add x3,x1,x2 (RegWrite_D=1, ALUControl_D=000, Rs1_D=1, Rs2_D=2, Rd_D=3, RD1_D=5, RD2_D=7) → next cycle RegWrite_E=1, Rd_E=3, RD1_E=5, RD2_E=7, Valid_E=1.
- Load-use: lw x5 captured, then add x6,x5,x1 in D → Stall_F=Stall_D=1 for exactly one cycle; EX shows a bubble (Valid_E=0, RegWrite_E=0); the add reaches EX one cycle later.
- x0 and no-match: lw x0 followed by use of x0, and lw x5 followed by add using x7,x8 → Stall_D stays 0.
- Branch flush: PCSrc_E=1 for one cycle → Flush_D=1 that cycle; next cycle Valid_E=0, MemWrite_E=0, Branch_E=0.
- With IDEX_PERF_CNT_EN: 3 load-use stalls plus 2 taken branches → stall_cnt=3, flush_cnt=2; assert rst → both counters 0.
